// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle
//   Memory stage plus M->W pipeline register of a 5-stage RV32 core.
//   Holds a word-organised data memory (combinational read, byte-enabled
//   synchronous write), extends load data, flags misaligned accesses and
//   produces the writeback value that also feeds the forwarding network.
//
//   Optional feature macro: MEM_SUBWORD_EN
//     defined   : byte/half/word loads and stores, misalignment detection,
//                 saturating misalignment counter.
//     undefined : every access is a full word; MemSizeM and ALUResultM[1:0]
//                 are ignored, MisalignM and MisalignCnt read as 0.
//
// Parameters
//   DEPTH_WORDS : data-memory depth in 32-bit words (power of two)
//   AW          : word-index width, log2(DEPTH_WORDS)
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   RegWriteM   : register-file write enable from execute
//   MemWriteM   : store enable
//   ResultSrcM  : result select (00 ALU, 01 load, 10 PC+4, 11 ALU)
//   MemSizeM    : funct3 access size/sign
//   ALUResultM  : byte address or ALU result
//   WriteDataM  : store data (already forwarded)
//   RDM         : destination register
//   PCPlus4M    : link value
//   RegWriteW   : registered register-file write enable
//   RDW         : registered destination register
//   ResultW     : writeback value / forwarding source
//   MisalignM   : combinational misaligned-access flag for this cycle
//   MisalignCnt : saturating count of misaligned accesses
// -----------------------------------------------------------------------------
module memory_cycle #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  MemSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RDM,
    input  logic [31:0] PCPlus4M,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW,
    output logic        MisalignM,
    output logic [7:0]  MisalignCnt
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    // Data memory: contents survive reset on purpose.
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] wordIdxS;
    logic [31:0]   memWordS;
    logic [31:0]   storeDataS;
    logic [31:0]   loadDataS;
    logic [3:0]    byteEnS;
    logic          misalignS;
    logic          storeEnS;

    // Writeback-stage pipeline registers
    logic [1:0]    ResultSrcW;
    logic [31:0]   ALUResultW;
    logic [31:0]   ReadDataW;
    logic [31:0]   PCPlus4W;

`ifdef MEM_SUBWORD_EN
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic       accessS;
    logic [7:0] misalignCntR;

    // Lane enables for a store; unknown size codes behave as SW.
    function automatic logic [3:0] storeLanes(input logic [2:0] size,
                                              input logic [1:0] off);
        logic [3:0] lanes;
        case (size)
            SZ_B:    lanes = 4'b0001 << off;
            SZ_H:    lanes = off[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    // Replicate the low store bytes onto every lane so the enables pick them.
    function automatic logic [31:0] storeAlign(input logic [2:0]  size,
                                               input logic [31:0] data);
        logic [31:0] aligned;
        case (size)
            SZ_B:    aligned = {4{data[7:0]}};
            SZ_H:    aligned = {2{data[15:0]}};
            default: aligned = data;
        endcase
        return aligned;
    endfunction

    // Select and extend the addressed lanes; unknown size codes behave as LW.
    function automatic logic [31:0] extendLoad(input logic [2:0]  size,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        logic [31:0] ext;
        byteVal = word[{off, 3'b000} +: 8];
        halfVal = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    ext = {{24{byteVal[7]}}, byteVal};
            SZ_H:    ext = {{16{halfVal[15]}}, halfVal};
            SZ_BU:   ext = {24'd0, byteVal};
            SZ_HU:   ext = {16'd0, halfVal};
            default: ext = word;
        endcase
        return ext;
    endfunction

    // Stores and loads decode size codes differently (e.g. 100 is SW for a
    // store but LBU for a load), so the access width depends on direction.
    function automatic logic isMisaligned(input logic       isStore,
                                          input logic [2:0] size,
                                          input logic [1:0] off);
        logic byteAcc;
        logic halfAcc;
        byteAcc = 1'b0;
        halfAcc = 1'b0;
        if (isStore) begin
            case (size)
                SZ_B:    byteAcc = 1'b1;
                SZ_H:    halfAcc = 1'b1;
                default: byteAcc = 1'b0;
            endcase
        end else begin
            case (size)
                SZ_B, SZ_BU: byteAcc = 1'b1;
                SZ_H, SZ_HU: halfAcc = 1'b1;
                default:     byteAcc = 1'b0;
            endcase
        end
        if (byteAcc) begin
            return 1'b0;
        end else if (halfAcc) begin
            return off[0];
        end else begin
            return off != 2'b00;
        end
    endfunction
`else
    // Size code has no meaning when every access is a full word.
    logic [2:0] unusedSizeS;
    assign unusedSizeS = MemSizeM;
`endif

    // Upper address bits are dropped so addresses wrap modulo the memory size.
    assign wordIdxS = ALUResultM[AW+1:2];
    assign memWordS = mem[wordIdxS];

    // Access decode: lane enables, aligned store data, load data, misalignment.
    always_comb begin
`ifdef MEM_SUBWORD_EN
        accessS    = MemWriteM | (ResultSrcM == SRC_LOAD);
        byteEnS    = storeLanes(MemSizeM, ALUResultM[1:0]);
        storeDataS = storeAlign(MemSizeM, WriteDataM);
        // Gated by rst so the flag reads 0 throughout reset.
        if (rst && accessS) begin
            misalignS = isMisaligned(MemWriteM, MemSizeM, ALUResultM[1:0]);
        end else begin
            misalignS = 1'b0;
        end
        if (misalignS) begin
            loadDataS = 32'd0;
        end else begin
            loadDataS = extendLoad(MemSizeM, ALUResultM[1:0], memWordS);
        end
`else
        byteEnS    = 4'b1111;
        storeDataS = WriteDataM;
        misalignS  = 1'b0;
        loadDataS  = memWordS;
`endif
    end

    assign storeEnS  = MemWriteM & rst & ~misalignS;
    assign MisalignM = misalignS;

    // Data memory write port: byte-enabled, blocked in reset and on misalignment.
    always_ff @(posedge clk) begin
        if (storeEnS) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEnS[b]) begin
                    mem[wordIdxS][b*8 +: 8] <= storeDataS[b*8 +: 8];
                end
            end
        end
    end

    // M->W pipeline registers; reset discards the in-flight entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= SRC_ALU;
            RDW        <= 5'd0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PCPlus4W   <= 32'd0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= loadDataS;
            PCPlus4W   <= PCPlus4M;
        end
    end

`ifdef MEM_SUBWORD_EN
    // Misalignment counter saturating at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalignCntR <= 8'd0;
        end else if (misalignS && (misalignCntR != 8'hFF)) begin
            misalignCntR <= misalignCntR + 8'd1;
        end else begin
            misalignCntR <= misalignCntR;
        end
    end

    assign MisalignCnt = misalignCntR;
`else
    assign MisalignCnt = 8'd0;
`endif

    // Writeback select; 11 aliases the ALU result.
    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            SRC_LOAD: ResultW = ReadDataW;
            SRC_PC4:  ResultW = PCPlus4W;
            default:  ResultW = ALUResultW;
        endcase
    end

endmodule
